// File: rtl/reg_feed_fifo.sv
// reg_feed_fifo: small synchronous FIFO that feeds an 8-bit enabled register.
// Producer writes are buffered and replayed as a registered d bus plus a
// one-cycle ena pulse per entry. A downstream hold pauses delivery without
// losing data. There is no first-word fall-through: an entry written into an
// empty FIFO is delivered one edge later at the earliest.
//
// Optional feature: define REG_FEED_FIFO_OVF_EN to add a sticky ovf output.
// ovf sets when a write is dropped because the FIFO is full and nothing pops
// on that edge. When the macro is undefined, the ovf port does not exist and
// dropped writes are not reported.
module reg_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hold,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] d,
  output logic             ena
`ifdef REG_FEED_FIFO_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Status flags come straight from the occupancy register.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Handshake decode on pre-edge state; a pop frees a slot for a write to a full FIFO.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each signal settles in one evaluation with no latch.
    pop  = !empty && !hold;
    push = wr_en && (!full || pop);
  end

  // Storage array: written on push, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; the pointers and count alone decide which entries are valid.
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy. A push together with a pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output stage: load d and pulse ena on each pop. On other edges d keeps its value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d   <= '0;
      ena <= 1'b0;
    end else begin
      ena <= pop;
      if (pop) d <= mem[rd_ptr];
    end
  end

`ifdef REG_FEED_FIFO_OVF_EN
  // Sticky overflow flag: a write request that is not accepted sets it. Only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              ovf <= 1'b0;
    else if (wr_en && !push) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_reg_feed_fifo.sv
// Testbench for reg_feed_fifo. The reference model is a queue of the entries
// the FIFO holds, plus the expected d/ena outputs and a copy of the downstream
// enabled register. A compare process checks the DUT against this model on
// every falling edge. Each directed scenario also checks a few hand-computed
// values.
module tb_reg_feed_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             hold;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic [WIDTH-1:0] d;
  logic             ena;
`ifdef REG_FEED_FIFO_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  reg_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .hold    (hold),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .d       (d),
    .ena     (ena)
`ifdef REG_FEED_FIFO_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Downstream 8-bit enabled register driven by the DUT outputs.
  logic [WIDTH-1:0] reg_q = '0;
  always @(posedge clk) if (ena) reg_q <= d;

  // Reference model.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_d   = '0;
  logic             exp_ena = 1'b0;
  logic             exp_ovf = 1'b0;
  logic [WIDTH-1:0] exp_q   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      exp_d   = '0;
      exp_ena = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      automatic bit was_full = (model_q.size() == DEPTH);
      automatic bit do_pop   = (model_q.size() != 0) && !hold;
      automatic bit do_push  = wr_en && (!was_full || do_pop);
      if (exp_ena) exp_q = exp_d;
      if (do_pop) begin
        exp_d   = model_q.pop_front();
        exp_ena = 1'b1;
      end else begin
        exp_ena = 1'b0;
      end
      if (do_push) model_q.push_back(wr_data);
      if (wr_en && !do_push) exp_ovf = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model away from the active edge.
  always @(negedge clk) begin
    check("m_count", 32'(count), 32'(model_q.size()));
    check("m_empty", 32'(empty), 32'(model_q.size() == 0));
    check("m_full",  32'(full),  32'(model_q.size() == DEPTH));
    check("m_ena",   32'(ena),   32'(exp_ena));
    check("m_d",     32'(d),     32'(exp_d));
    check("m_q",     32'(reg_q), 32'(exp_q));
`ifdef REG_FEED_FIFO_OVF_EN
    check("m_ovf",   32'(ovf),   32'(exp_ovf));
`endif
  end

  // One clock cycle: drive inputs, take the rising edge, and settle 1 time unit after it.
  task automatic cycle(input logic we, input logic [WIDTH-1:0] data, input logic hld);
    wr_en   = we;
    wr_data = data;
    hold    = hld;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check it takes effect at once, then release it.
  task automatic async_reset(input string tag);
    wr_en = 1'b0;
    hold  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_ena"},   32'(ena),   32'd0);
    check({tag, "_d"},     32'(d),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] got[$];

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; hold = 1'b0;
    #1;
    check("por_count", 32'(count), 32'd0);
    check("por_empty", 32'(empty), 32'd1);
    check("por_ena",   32'(ena),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Stream of three writes with hold low.
    cycle(1'b1, 8'h11, 1'b0);
    check("s_ena0", 32'(ena), 32'd0);
    cycle(1'b1, 8'h22, 1'b0);
    check("s_ena1", 32'(ena), 32'd1); check("s_d1", 32'(d), 32'h11);
    cycle(1'b1, 8'h33, 1'b0);
    check("s_ena2", 32'(ena), 32'd1); check("s_d2", 32'(d), 32'h22);
    cycle(1'b0, 8'h00, 1'b0);
    check("s_ena3", 32'(ena), 32'd1); check("s_d3", 32'(d), 32'h33);
    cycle(1'b0, 8'h00, 1'b0);
    check("s_ena4", 32'(ena), 32'd0); check("s_q", 32'(reg_q), 32'h33);

    // Asynchronous reset while three entries are held.
    cycle(1'b1, 8'h41, 1'b1);
    cycle(1'b1, 8'h42, 1'b1);
    cycle(1'b1, 8'h43, 1'b1);
    check("r_pre_count", 32'(count), 32'd3);
    async_reset("r");

    // Fill under hold, drop the fifth write, then drain.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1);
    check("f_full",  32'(full),  32'd1);
    check("f_count", 32'(count), 32'd4);
    cycle(1'b1, 8'h05, 1'b1);
    check("f_drop_count", 32'(count), 32'd4);
`ifdef REG_FEED_FIFO_OVF_EN
    check("f_ovf", 32'(ovf), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      check("f_ena", 32'(ena), 32'd1);
      check("f_d",   32'(d),   32'(i));
    end
    cycle(1'b0, 8'h00, 1'b0);
    check("f_end_ena",   32'(ena),   32'd0);
    check("f_end_empty", 32'(empty), 32'd1);

    async_reset("r2");

    // A write to a full FIFO is accepted when a pop happens on the same edge.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b1);
    cycle(1'b1, 8'hAA, 1'b0);
    check("x_count", 32'(count), 32'd4);
    check("x_d0",    32'(d),     32'hB1);
    cycle(1'b0, 8'h00, 1'b0); check("x_d1", 32'(d), 32'hB2);
    cycle(1'b0, 8'h00, 1'b0); check("x_d2", 32'(d), 32'hB3);
    cycle(1'b0, 8'h00, 1'b0); check("x_d3", 32'(d), 32'hB4);
    cycle(1'b0, 8'h00, 1'b0); check("x_d4", 32'(d), 32'hAA); check("x_ena4", 32'(ena), 32'd1);
    cycle(1'b0, 8'h00, 1'b0); check("x_end_ena", 32'(ena), 32'd0);
`ifdef REG_FEED_FIFO_OVF_EN
    check("x_ovf", 32'(ovf), 32'd0);
`endif

    // Hold for two cycles in the middle of a drain.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b0); check("h_d1", 32'(d), 32'hC1);
    cycle(1'b0, 8'h00, 1'b0); check("h_d2", 32'(d), 32'hC2);
    cycle(1'b0, 8'h00, 1'b1); check("h_ena_a", 32'(ena), 32'd0); check("h_d_a", 32'(d), 32'hC2);
    cycle(1'b0, 8'h00, 1'b1); check("h_ena_b", 32'(ena), 32'd0); check("h_d_b", 32'(d), 32'hC2);
    cycle(1'b0, 8'h00, 1'b0); check("h_d3", 32'(d), 32'hC3); check("h_ena3", 32'(ena), 32'd1);
    cycle(1'b0, 8'h00, 1'b0); check("h_d4", 32'(d), 32'hC4);

    // Pointer wrap: ten writes with pops interleaved, occupancy stays within 1..3.
    for (int i = 0; i < 10; i++) begin
      sent.push_back(8'(8'hD0 + i));
      cycle(1'b1, 8'(8'hD0 + i), (i == 2 || i == 5));
      if (ena) got.push_back(d);
    end
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (ena) got.push_back(d);
      if (!ena && empty) break;
    end
    check("w_num", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) check("w_order", 32'(got[i]), 32'(sent[i]));
    end
    check("w_empty", 32'(empty), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
